// File: rtl/garo_trng_pkg.sv
// Shared types and helpers for the GARO word-level entropy source.
// Contents: output/debias state enums and the ring tap-mask generator.
package garo_trng_pkg;

  localparam int unsigned MAX_STAGES = 64;
  localparam int unsigned TAP_IDX_W  = $clog2(MAX_STAGES);

  typedef enum logic [1:0] {
    OUT_EMPTY = 2'd0,
    OUT_FULL  = 2'd1,
    OUT_FAIL  = 2'd2
  } out_state_e;

  typedef enum logic {
    DB_IDLE       = 1'b0,
    DB_HAVE_FIRST = 1'b1
  } db_state_e;

  // XOR feedback taps for a Galois ring of the given length.
  // Taps sit near the start, middle and end so every stage sees feedback quickly.
  function automatic logic [MAX_STAGES-1:0] ring_taps(input int unsigned stages);
    logic [MAX_STAGES-1:0] mask;
    mask = '0;
    if (stages >= 5 && stages <= MAX_STAGES) begin
      mask[TAP_IDX_W'(1)]          = 1'b1;
      mask[TAP_IDX_W'(stages / 2)] = 1'b1;
      mask[TAP_IDX_W'(stages - 2)] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/garo_trng_word_cell.sv
// One entropy channel: a gated Galois ring oscillator (or the test_bit
// substitute when SIM_MODEL=1) followed by its synchroniser chain.
// Ports: clk, reset (sync, active-low), enable (ring run gate),
//        test_bit (simulation substitute), sync_bit (synchronised sample).
module garo_cell
  import garo_trng_pkg::*;
#(
  parameter int unsigned           STAGES      = 31,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter bit                    SIM_MODEL   = 1'b0,
  parameter logic [MAX_STAGES-1:0] TAPS        = ring_taps(STAGES)
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic test_bit,
  output logic sync_bit
);

  logic ring_out;

  if (SIM_MODEL) begin : g_sim
    // Rings are replaced wholesale; the run gate only matters downstream.
    logic unused_enable;
    assign unused_enable = enable;
    assign ring_out      = test_bit;
  end else begin : g_ring
    (* keep = "true", dont_touch = "true" *) logic [STAGES-1:0] stage;
    (* keep = "true", dont_touch = "true" *) logic              fb;
    logic unused_test_bit;
    assign unused_test_bit = test_bit;

    // Gating the feedback with enable freezes every stage when the ring is stopped.
    assign fb       = stage[STAGES-1] & enable;
    assign stage[0] = ~fb;
    for (genvar i = 1; i < STAGES; i++) begin : g_stage
      assign stage[i] = ~(stage[i-1] ^ (TAPS[i] & fb));
    end
    assign ring_out = stage[STAGES-1];
  end

  // Synchroniser chain; bit 0 takes the asynchronous sample.
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ring_out};
    end
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/garo_trng_word.sv
// Multi-channel GARO entropy source producing debiased WIDTH-bit words.
// Ports: clk, reset (sync, active-low), enable, test_bits[CHANNELS],
//        out_data/out_valid/out_ready (word handshake), health_fail (sticky
//        repetition-count alarm), raw_bit (combined pre-debias sample).
module garo_trng_word
  import garo_trng_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned STAGES      = 31,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned REP_LIMIT   = 32,
  parameter bit          SIM_MODEL   = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] test_bits,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                health_fail,
  output logic                raw_bit
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned RUN_W = 8;

  // Entropy channels
  logic [CHANNELS-1:0] sync_bits;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_cell
    garo_cell #(
      .STAGES     (STAGES),
      .SYNC_STAGES(SYNC_STAGES),
      .SIM_MODEL  (SIM_MODEL),
      .TAPS       (ring_taps(STAGES))
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .test_bit(test_bits[c]),
      .sync_bit(sync_bits[c])
    );
  end

  logic comb_c;
  assign comb_c = ^sync_bits;

  // Raw sample register and repetition-count health test.
  // raw_valid marks a raw_bit that was captured while enabled.
  logic             raw_valid;
  logic [RUN_W-1:0] run_cnt;
  logic             trip_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      raw_bit     <= 1'b0;
      raw_valid   <= 1'b0;
      run_cnt     <= '0;
      health_fail <= 1'b0;
    end else begin
      if (run_cnt >= RUN_W'(REP_LIMIT)) health_fail <= 1'b1;
      if (enable) begin
        raw_bit   <= comb_c;
        raw_valid <= 1'b1;
        if (run_cnt != '0 && comb_c == raw_bit) begin
          if (run_cnt < RUN_W'(REP_LIMIT)) run_cnt <= run_cnt + RUN_W'(1);
        end else begin
          run_cnt <= RUN_W'(1);
        end
      end else begin
        raw_valid <= 1'b0;
        run_cnt   <= '0;
      end
    end
  end

  assign trip_c = health_fail || (run_cnt >= RUN_W'(REP_LIMIT));

  // State and datapath registers
  db_state_e        db_state, db_state_next;
  out_state_e       out_state, out_state_next;
  logic             first_bit, first_bit_next;
  logic [WIDTH-1:0] shift_q, shift_next, out_data_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      db_state  <= DB_IDLE;
      out_state <= OUT_EMPTY;
      first_bit <= 1'b0;
      shift_q   <= '0;
      cnt_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      db_state  <= db_state_next;
      out_state <= out_state_next;
      first_bit <= first_bit_next;
      shift_q   <= shift_next;
      cnt_q     <= cnt_next;
      out_data  <= out_data_next;
      out_valid <= (out_state_next == OUT_FULL);
    end
  end

  // Von Neumann debiaser: the first bit of an unequal pair is the output.
  logic emit_c;

  always_comb begin
    db_state_next  = db_state;
    first_bit_next = first_bit;
    emit_c         = 1'b0;
    if (!enable) begin
      db_state_next = DB_IDLE;
    end else if (raw_valid) begin
      if (db_state == DB_IDLE) begin
        first_bit_next = raw_bit;
        db_state_next  = DB_HAVE_FIRST;
      end else begin
        emit_c        = first_bit ^ raw_bit;
        db_state_next = DB_IDLE;
      end
    end
  end

  // Packer and output handshake FSM
  logic xfer_c;
  logic pack_full_c;

  always_comb begin
    out_state_next = out_state;
    shift_next     = shift_q;
    cnt_next       = cnt_q;
    out_data_next  = out_data;
    xfer_c         = out_valid && out_ready;
    pack_full_c    = (cnt_q == CNT_W'(WIDTH));

    // Bits arriving while a completed word waits are dropped.
    if (emit_c && !pack_full_c) begin
      shift_next = {first_bit, shift_q[WIDTH-1:1]};
      cnt_next   = cnt_q + CNT_W'(1);
    end
    if (!enable) cnt_next = '0;

    case (out_state)
      OUT_EMPTY: begin
        if (pack_full_c) begin
          out_data_next  = shift_q;
          cnt_next       = '0;
          out_state_next = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (xfer_c) begin
          if (pack_full_c) begin
            out_data_next = shift_q;
            cnt_next      = '0;
          end else begin
            out_state_next = OUT_EMPTY;
          end
        end
      end
      OUT_FAIL: ;
      default: out_state_next = OUT_EMPTY;
    endcase

    // A tripped health test freezes the packer and holds the last word.
    if (trip_c) begin
      out_state_next = OUT_FAIL;
      shift_next     = shift_q;
      cnt_next       = cnt_q;
      out_data_next  = out_data;
    end
  end

endmodule
